aq32_sram_ctrl: RTL and testbench

Bridges the AQ32 core's 32-bit word bus to the external 512KB x8 SRAM on the expansion bus (ram_a[18:0], ram_ce_n, ram_we_n, ram_oe_n, ebus_d). It serialises each word access into four byte cycles with programmable SRAM timing. It sits directly downstream of the top level's RAM signals, which are tied inactive today. The top level owns the ebus_d tristate; this block only supplies the data out, output enable and data in.

---
 rtl/aq32_sram_ctrl_pkg.sv | 33 +++
 rtl/aq32_sram_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_aq32_sram_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq32_sram_ctrl_pkg.sv
// aq32_sram_ctrl_pkg
// Shared definitions for the AQ32 word-bus to x8 SRAM bridge:
//   - SRAM_AW / WORD_AW : byte and word address widths of the 512KB SRAM
//   - state_e           : byte sequencer states
//   - find_byte()       : picks the next enabled byte lane for writes
package aq32_sram_ctrl_pkg;

    localparam int SRAM_AW = 19;
    localparam int WORD_AW = SRAM_AW - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_e;

    // Returns {found, lane}: the lowest set lane of sel at or above start.
    // start may be 4, meaning "past the last lane", which always yields found=0.
    function automatic logic [2:0] find_byte(input logic [3:0] sel, input logic [2:0] start);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i] && (i >= int'(start))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aq32_sram_ctrl.sv
// aq32_sram_ctrl
// Serialises 32-bit AQ32 bus accesses into four byte cycles on an external
// 512KB x8 SRAM. Reads always fetch all four bytes; writes only touch lanes
// enabled in bus_bytesel. Every output is a flop.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   bus_addr/wrdata/bytesel    : word address, write data, write byte enables
//   bus_wren, bus_strobe       : request qualifiers (held until bus_ack)
//   bus_ack, bus_rddata        : one-cycle completion pulse, read word
//   ram_a, ram_ce_n/we_n/oe_n  : SRAM address and strobes
//   ram_d_out, ram_d_oe        : write data and drive enable for the ebus_d pad
//   ram_d_in                   : ebus_d pad input
module aq32_sram_ctrl
    import aq32_sram_ctrl_pkg::*;
#(
    parameter int RD_CYCLES = 2,
    parameter int WE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WORD_AW-1:0] bus_addr,
    input  logic [31:0]        bus_wrdata,
    input  logic [3:0]         bus_bytesel,
    input  logic               bus_wren,
    input  logic               bus_strobe,
    output logic               bus_ack,
    output logic [31:0]        bus_rddata,
    output logic [SRAM_AW-1:0] ram_a,
    output logic               ram_ce_n,
    output logic               ram_we_n,
    output logic               ram_oe_n,
    output logic [7:0]         ram_d_out,
    output logic               ram_d_oe,
    input  logic [7:0]         ram_d_in
);

    localparam int CNT_MAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_AW-1:0]  addr_q, addr_d;
    logic [31:0]         wrdata_q, wrdata_d;
    logic [3:0]          bytesel_q, bytesel_d;
    logic [23:0]         rd_buf_q, rd_buf_d;
    logic [31:0]         rddata_q, rddata_d;
    logic [SRAM_AW-1:0]  ram_a_q, ram_a_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic [7:0]          d_out_q, d_out_d;
    logic                d_oe_q, d_oe_d;
    logic                ack_q, ack_d;
    logic [2:0]          lane;

    // Sequencer next-state. Reads/writes are distinguished by the state path
    // taken at accept time, so wren itself need not be kept.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wrdata_d  = wrdata_q;
        bytesel_d = bytesel_q;
        rd_buf_d  = rd_buf_q;
        rddata_d  = rddata_q;
        lane      = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (bus_strobe) begin
                    addr_d    = bus_addr;
                    wrdata_d  = bus_wrdata;
                    bytesel_d = bus_bytesel;
                    cnt_d     = '0;
                    if (bus_wren) begin
                        lane = find_byte(bus_bytesel, 3'd0);
                        if (lane[2]) begin
                            state_d = ST_WR_SETUP;
                            idx_d   = lane[1:0];
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_RD;
                        idx_d   = 2'd0;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == RD_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        // Publish the whole word at once so bus_rddata only
                        // changes when a read completes.
                        rddata_d = {ram_d_in, rd_buf_q};
                        state_d  = ST_DONE;
                    end else begin
                        rd_buf_d[{idx_q, 3'b000} +: 8] = ram_d_in;
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = '0;
            end
            ST_WR_PULSE: begin
                if (cnt_q == WE_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_HOLD: begin
                lane = find_byte(bytesel_q, {1'b0, idx_q} + 3'd1);
                if (lane[2]) begin
                    state_d = ST_WR_SETUP;
                    idx_d   = lane[1:0];
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values are decoded from the *next* state so they can be registered
    // and still line up with the state they belong to. Address and write data
    // only move on entry to RD or WR_SETUP, where we_n is high, so we_n never
    // falls on an address change. Outside an access the address and data just
    // hold.
    always_comb begin
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        d_oe_d  = 1'b0;
        ack_d   = 1'b0;
        ram_a_d = ram_a_q;
        d_out_d = d_out_q;

        case (state_d)
            ST_RD: begin
                ce_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                ram_a_d = {addr_d, idx_d};
            end
            ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
                ce_n_d  = 1'b0;
                d_oe_d  = 1'b1;
                we_n_d  = (state_d != ST_WR_PULSE);
                ram_a_d = {addr_d, idx_d};
                d_out_d = wrdata_d[{idx_d, 3'b000} +: 8];
            end
            ST_DONE: begin
                ack_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wrdata_q  <= '0;
            bytesel_q <= '0;
            rd_buf_q  <= '0;
            rddata_q  <= '0;
            ram_a_q   <= '0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            d_out_q   <= '0;
            d_oe_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wrdata_q  <= wrdata_d;
            bytesel_q <= bytesel_d;
            rd_buf_q  <= rd_buf_d;
            rddata_q  <= rddata_d;
            ram_a_q   <= ram_a_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            d_out_q   <= d_out_d;
            d_oe_q    <= d_oe_d;
            ack_q     <= ack_d;
        end
    end

    assign bus_ack    = ack_q;
    assign bus_rddata = rddata_q;
    assign ram_a      = ram_a_q;
    assign ram_ce_n   = ce_n_q;
    assign ram_we_n   = we_n_q;
    assign ram_oe_n   = oe_n_q;
    assign ram_d_out  = d_out_q;
    assign ram_d_oe   = d_oe_q;

endmodule

// File: tb/tb_aq32_sram_ctrl.sv
// tb_aq32_sram_ctrl
// Directed bench for aq32_sram_ctrl. Two instances share the bus inputs:
// u_dut with default timing and u_fast with RD_CYCLES=WE_CYCLES=1, each with
// its own behavioural x8 SRAM. Each test task drives one scenario and
// checks its own results.
module tb_aq32_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] bus_addr = '0;
    logic [31:0] bus_wrdata = '0;
    logic [3:0]  bus_bytesel = '0;
    logic        bus_wren = 1'b0;
    logic        bus_strobe = 1'b0;
    logic        bus_ack;
    logic [31:0] bus_rddata;
    logic [18:0] ram_a;
    logic        ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe;
    logic [7:0]  ram_d_out, ram_d_in;

    logic        f_strobe = 1'b0;
    logic        f_ack;
    logic [31:0] f_rddata;
    logic [18:0] f_a;
    logic        f_ce_n, f_we_n, f_oe_n, f_d_oe;
    logic [7:0]  f_d_out, f_d_in;

    logic [7:0]  mem   [0:524287];
    logic [7:0]  mem_f [0:524287];

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor counters for the default-timing instance
    int   ce_low = 0, oe_low = 0, we_low = 0, we_falls = 0;
    int   overlap_err = 0, wefall_err = 0;
    logic prev_we = 1'b1;
    logic [18:0] prev_a = '0;

    always #5 clk = ~clk;

    aq32_sram_ctrl u_dut (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_bytesel(bus_bytesel),
        .bus_wren(bus_wren), .bus_strobe(bus_strobe),
        .bus_ack(bus_ack), .bus_rddata(bus_rddata),
        .ram_a(ram_a), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
        .ram_d_out(ram_d_out), .ram_d_oe(ram_d_oe), .ram_d_in(ram_d_in)
    );

    aq32_sram_ctrl #(.RD_CYCLES(1), .WE_CYCLES(1)) u_fast (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_bytesel(bus_bytesel),
        .bus_wren(bus_wren), .bus_strobe(f_strobe),
        .bus_ack(f_ack), .bus_rddata(f_rddata),
        .ram_a(f_a), .ram_ce_n(f_ce_n), .ram_we_n(f_we_n), .ram_oe_n(f_oe_n),
        .ram_d_out(f_d_out), .ram_d_oe(f_d_oe), .ram_d_in(f_d_in)
    );

    // Behavioural SRAMs: read data while CE and OE are low, write latched on
    // the rising edge of WE while CE is still low.
    assign ram_d_in = (!ram_ce_n && !ram_oe_n) ? mem[ram_a] : 8'h00;
    assign f_d_in   = (!f_ce_n && !f_oe_n) ? mem_f[f_a] : 8'h00;

    always @(posedge ram_we_n) begin
        if (ram_ce_n === 1'b0 && ram_d_oe === 1'b1) mem[ram_a] = ram_d_out;
    end

    always @(posedge f_we_n) begin
        if (f_ce_n === 1'b0 && f_d_oe === 1'b1) mem_f[f_a] = f_d_out;
    end

    // Pin-level protocol watcher, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (!ram_ce_n) ce_low++;
            if (!ram_oe_n) oe_low++;
            if (!ram_we_n) we_low++;
            if (!ram_oe_n && ram_d_oe) overlap_err++;
            if (prev_we && !ram_we_n) begin
                we_falls++;
                if (ram_a != prev_a) wefall_err++;
            end
        end
        prev_we = ram_we_n;
        prev_a  = ram_a;
    end

    // Drives one request on u_dut and waits (bounded) for bus_ack; lat is the
    // cycle count from the accept edge, -1 on timeout. Returns in IDLE.
    task automatic do_access(input logic wr, input logic [16:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int lat);
        bus_addr = a; bus_wrdata = d; bus_bytesel = s; bus_wren = wr; bus_strobe = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus_ack) begin lat = k; break; end
        end
        bus_strobe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_access_fast(input logic wr, input logic [16:0] a, input logic [31:0] d,
                                  input logic [3:0] s, output int lat);
        bus_addr = a; bus_wrdata = d; bus_bytesel = s; bus_wren = wr; f_strobe = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (f_ack) begin lat = k; break; end
        end
        f_strobe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({bus_ack, ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe} !== 5'b01110) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got ack,ce,we,oe,doe=%b required 01110",
                     {bus_ack, ram_ce_n, ram_we_n, ram_oe_n, ram_d_oe});
        end
        n_checks++;
        if (ram_a !== 19'h0 || ram_d_out !== 8'h00 || bus_rddata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got a=%h dout=%h rd=%h required all zero",
                     ram_a, ram_d_out, bus_rddata);
        end
    endtask

    task automatic test_read;
        int   lat;
        int   bad_a, base_we;
        logic [18:0] exp_a;
        base_we = we_low;
        bad_a = 0;
        lat = -1;
        bus_addr = 17'h040; bus_wren = 1'b0; bus_bytesel = 4'b0000; bus_strobe = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k <= 8) begin
                exp_a = 19'h100 + 19'((k - 1) / 2);
                if (ram_a !== exp_a || ram_oe_n !== 1'b0) bad_a++;
            end
            if (bus_ack) begin lat = k; break; end
        end
        bus_strobe = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (lat !== 9) begin
            n_fail++; $display("[TB] FAIL read_latency: got %0d required 9", lat);
        end
        n_checks++;
        if (bus_rddata !== 32'h44332211) begin
            n_fail++; $display("[TB] FAIL read_data: got %h required 44332211", bus_rddata);
        end
        n_checks++;
        if (bad_a !== 0) begin
            n_fail++; $display("[TB] FAIL read_addr_seq: got %0d bad cycles required 0", bad_a);
        end
        n_checks++;
        if (we_low - base_we !== 0) begin
            n_fail++; $display("[TB] FAIL read_we_quiet: got %0d we low cycles required 0", we_low - base_we);
        end
    endtask

    task automatic test_full_write;
        int lat, b_falls, b_we, b_oe;
        b_falls = we_falls; b_we = we_low; b_oe = oe_low;
        do_access(1'b1, 17'h1FFFF, 32'hDEADBEEF, 4'b1111, lat);
        n_checks++;
        if (lat !== 17) begin
            n_fail++; $display("[TB] FAIL fullwr_latency: got %0d required 17", lat);
        end
        n_checks++;
        if ({mem[19'h7FFFF], mem[19'h7FFFE], mem[19'h7FFFD], mem[19'h7FFFC]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL fullwr_data: got %h%h%h%h required DEADBEEF",
                     mem[19'h7FFFF], mem[19'h7FFFE], mem[19'h7FFFD], mem[19'h7FFFC]);
        end
        n_checks++;
        if (we_falls - b_falls !== 4 || we_low - b_we !== 8) begin
            n_fail++;
            $display("[TB] FAIL fullwr_pulses: got %0d pulses %0d low cycles required 4 and 8",
                     we_falls - b_falls, we_low - b_we);
        end
        n_checks++;
        if (oe_low - b_oe !== 0) begin
            n_fail++; $display("[TB] FAIL fullwr_oe_quiet: got %0d oe low cycles required 0", oe_low - b_oe);
        end
    endtask

    task automatic test_sparse_write;
        int lat, b_falls, b_ce;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        b_falls = we_falls;
        do_access(1'b1, 17'h0, 32'hAABBCCDD, 4'b1010, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++; $display("[TB] FAIL sparse_latency: got %0d required 9", lat);
        end
        n_checks++;
        if ({mem[3], mem[2], mem[1], mem[0]} !== 32'hAA03CC01) begin
            n_fail++;
            $display("[TB] FAIL sparse_data: got %h%h%h%h required AA03CC01", mem[3], mem[2], mem[1], mem[0]);
        end
        n_checks++;
        if (we_falls - b_falls !== 2) begin
            n_fail++; $display("[TB] FAIL sparse_pulses: got %0d required 2", we_falls - b_falls);
        end
        b_ce = ce_low;
        do_access(1'b1, 17'h0, 32'h11111111, 4'b0000, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("[TB] FAIL nosel_latency: got %0d required 1", lat);
        end
        n_checks++;
        if (ce_low - b_ce !== 0 || {mem[3], mem[2], mem[1], mem[0]} !== 32'hAA03CC01) begin
            n_fail++;
            $display("[TB] FAIL nosel_quiet: got %0d ce low cycles, mem %h%h%h%h required 0, AA03CC01",
                     ce_low - b_ce, mem[3], mem[2], mem[1], mem[0]);
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2;
        lat1 = -1; lat2 = -1;
        bus_addr = 17'h0123; bus_wrdata = 32'h0BADF00D; bus_bytesel = 4'b1111;
        bus_wren = 1'b1; bus_strobe = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus_ack) begin lat1 = k; break; end
        end
        // Strobe stays up; the request turns into a read of the same word.
        bus_wren = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus_ack) begin lat2 = k; break; end
        end
        bus_strobe = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (lat1 !== 17 || lat2 !== 10) begin
            n_fail++; $display("[TB] FAIL b2b_latency: got %0d/%0d required 17/10", lat1, lat2);
        end
        n_checks++;
        if (bus_rddata !== 32'h0BADF00D) begin
            n_fail++; $display("[TB] FAIL b2b_data: got %h required 0BADF00D", bus_rddata);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat, acks;
        bus_addr = 17'h0004; bus_wrdata = 32'h12345678; bus_bytesel = 4'b1111;
        bus_wren = 1'b1; bus_strobe = 1'b1;
        // Byte 2: setup at T+9, first pulse cycle at T+10
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (ram_we_n !== 1'b0 || ram_a !== 19'h12) begin
            n_fail++; $display("[TB] FAIL rst_precond: got we_n=%b a=%h required 0 and 00012", ram_we_n, ram_a);
        end
        reset = 1'b1; bus_strobe = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({ram_we_n, ram_ce_n, ram_oe_n, ram_d_oe, bus_ack} !== 5'b11100) begin
            n_fail++;
            $display("[TB] FAIL rst_midwrite: got we,ce,oe,doe,ack=%b required 11100",
                     {ram_we_n, ram_ce_n, ram_oe_n, ram_d_oe, bus_ack});
        end
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus_ack) acks++;
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++; $display("[TB] FAIL rst_noack: got %0d acks required 0", acks);
        end
        do_access(1'b0, 17'h040, 32'h0, 4'b0000, lat);
        n_checks++;
        if (lat !== 9 || bus_rddata !== 32'h44332211) begin
            n_fail++; $display("[TB] FAIL rst_recover: got lat %0d data %h required 9 44332211", lat, bus_rddata);
        end
    endtask

    task automatic test_fast_timing;
        int lat;
        do_access_fast(1'b0, 17'h040, 32'h0, 4'b0000, lat);
        n_checks++;
        if (lat !== 5 || f_rddata !== 32'h44332211) begin
            n_fail++; $display("[TB] FAIL fast_read: got lat %0d data %h required 5 44332211", lat, f_rddata);
        end
        do_access_fast(1'b1, 17'h0020, 32'hCAFEF00D, 4'b1111, lat);
        n_checks++;
        if (lat !== 13) begin
            n_fail++; $display("[TB] FAIL fast_write_latency: got %0d required 13", lat);
        end
        n_checks++;
        if ({mem_f[19'h83], mem_f[19'h82], mem_f[19'h81], mem_f[19'h80]} !== 32'hCAFEF00D) begin
            n_fail++;
            $display("[TB] FAIL fast_write_data: got %h%h%h%h required CAFEF00D",
                     mem_f[19'h83], mem_f[19'h82], mem_f[19'h81], mem_f[19'h80]);
        end
        do_access_fast(1'b0, 17'h0020, 32'h0, 4'b0000, lat);
        n_checks++;
        if (lat !== 5 || f_rddata !== 32'hCAFEF00D) begin
            n_fail++; $display("[TB] FAIL fast_readback: got lat %0d data %h required 5 CAFEF00D", lat, f_rddata);
        end
    endtask

    task automatic test_protocol;
        n_checks++;
        if (overlap_err !== 0) begin
            n_fail++; $display("[TB] FAIL oe_doe_overlap: got %0d cycles required 0", overlap_err);
        end
        n_checks++;
        if (wefall_err !== 0) begin
            n_fail++; $display("[TB] FAIL we_fall_addr: got %0d events required 0", wefall_err);
        end
    endtask

    initial begin
        mem[19'h100] = 8'h11; mem[19'h101] = 8'h22; mem[19'h102] = 8'h33; mem[19'h103] = 8'h44;
        mem_f[19'h100] = 8'h11; mem_f[19'h101] = 8'h22; mem_f[19'h102] = 8'h33; mem_f[19'h103] = 8'h44;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_read();
        test_full_write();
        test_sparse_write();
        test_back_to_back();
        test_reset_mid_write();
        test_fast_timing();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
